debug_mem_reader: RTL
=====================

Name: debug_mem_reader

Overview:
Debug-side reader for the data memory that the MEM stage writes. It runs while the pipeline is halted. It walks a window of data-memory words through an asynchronous read port and serializes each word into bytes, MSB first, over a valid/ready byte stream that feeds the UART TX of the debug unit. It sits between the data memory's debug read port and the debug unit's transmit path.

Parameters:
NB_DATA, 32, data memory word width; must be a multiple of 8; BYTES = NB_DATA/8
NB_ADDR, 8, data memory word-address width; addresses wrap modulo 2^NB_ADDR

Ports:
clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  single-cycle request to begin a dump
i_halt  in  1  pipeline halted; dump is allowed only while high
i_base_addr  in  NB_ADDR  first word address, sampled on accepted start
i_count  in  NB_ADDR+1  number of words to dump, 0..2^NB_ADDR, sampled on accepted start
o_mem_addr  out  NB_ADDR  read address to the data memory (registered)
i_mem_data  in  NB_DATA  combinational read data for o_mem_addr
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  sink accepts the byte; a handshake occurs when valid & ready
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse when the dump completes normally
o_aborted  out  1  one-cycle pulse when the dump is abandoned because i_halt went low

Behaviour:
- Reset (asynchronous): state=IDLE; o_mem_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, o_aborted=0; internal word register, byte index and remaining counter = 0.
- IDLE: a start is accepted when i_start & i_halt are high at edge T.
  - On acceptance, latch addr=i_base_addr and remaining=i_count.
  - Go to DONE if i_count==0; otherwise go to LOAD.
  - i_start while busy is ignored. i_start with i_halt low is ignored; no pulse is produced.
- LOAD (one cycle): o_mem_addr holds the current addr.
  - If i_halt==0: go to IDLE and pulse o_aborted in the next cycle.
  - Otherwise capture i_mem_data into the word register, clear byte index, go to SEND.
  - Latency: for a start at edge T, o_tx_valid first rises after edge T+2.
- SEND: o_tx_valid=1; o_tx_data = word register bits [NB_DATA-1:NB_DATA-8].
  - o_tx_data and o_tx_valid stay stable while i_tx_ready is low. No byte is ever dropped or duplicated.
  - On each handshake: shift the word left by 8 and increment the byte index.
  - On the handshake of byte BYTES-1: decrement remaining.
    - If remaining was 1: go to DONE.
    - Otherwise: addr = addr+1 (wraps 2^NB_ADDR-1 to 0), go to LOAD.
  - o_tx_valid drops in the cycle after the final handshake of each word. There is one LOAD bubble per word.
  - i_halt is not checked in SEND; the current word always completes.
- DONE (one cycle): o_done=1, o_busy=1, then go to IDLE.
- A full window (i_count = 2^NB_ADDR) covers every address exactly once, starting at i_base_addr.
- Throughput: BYTES+1 cycles per word when i_tx_ready is held high.
- Reset mid-dump: an immediate return to reset values; no done or aborted pulse.

Optional Feature:
DBG_MEM_ADDR_TAG_EN.
- Defined: each word is preceded by one tag byte, the low 8 bits of addr zero-extended when NB_ADDR<8. The tag goes out in SEND under the same handshake rules, so each word is BYTES+1 bytes. Latency and bubble rules are unchanged.
- Undefined: data bytes only.

Test Plan:
- mem[0x10]=0xDEADBEEF, base=0x10, count=1, ready=1 -> bytes DE,AD,BE,EF on 4 consecutive cycles starting 2 cycles after start; o_done pulses 1 cycle after the EF handshake.
- mem[0xFF]=0x11223344, mem[0x00]=0x55667788, base=0xFF, count=2 -> o_mem_addr 0xFF then 0x00; bytes 11,22,33,44,55,66,77,88; one bubble between the two words.
- count=0 -> o_tx_valid never rises; o_done pulses at T+2 (state is DONE after edge T+1); o_busy is high for 1 cycle.
- Backpressure: hold i_tx_ready low for 5 cycles during byte AD of 0xDEADBEEF -> o_tx_data stays 0xAD and valid stays high; the stream resumes with BE with no loss.
- i_halt low at start -> no activity. i_halt dropped mid-word on count=3 -> the current word finishes, o_aborted pulses, o_done never pulses.
- Assert i_rst_n low during SEND -> all outputs 0 immediately. With DBG_MEM_ADDR_TAG_EN, case 1 gives 10,DE,AD,BE,EF.

Source files
------------

// File: rtl/debug_mem_reader_if.sv
// Memory debug-read port plus byte stream toward the debug UART TX.
// master = reader side, slave = memory / transmitter side.
interface debug_mem_reader_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
);
    logic [NB_ADDR-1:0] mem_addr;
    logic [NB_DATA-1:0] mem_data;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (
        output mem_addr, tx_data, tx_valid,
        input  mem_data, tx_ready
    );

    modport slave (
        input  mem_addr, tx_data, tx_valid,
        output mem_data, tx_ready
    );
endinterface

// File: rtl/debug_mem_reader.sv
// Halted-pipeline data-memory dump: reads a word window and streams it MSB byte first.
// Optional DBG_MEM_ADDR_TAG_EN prefixes every word with an address tag byte.
module debug_mem_reader #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_halt,
    input  logic [NB_ADDR-1:0]   i_base_addr,
    input  logic [NB_ADDR:0]     i_count,
    debug_mem_reader_if.master   bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_aborted
);
    localparam int BYTES = NB_DATA / 8;
`ifdef DBG_MEM_ADDR_TAG_EN
    localparam int NBYTES = BYTES + 1;
`else
    localparam int NBYTES = BYTES;
`endif
    localparam int NB_IDX = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t               state, state_next;
    logic                 armed;
    logic                 aborted_q;
    logic [NB_ADDR-1:0]   addr;
    logic [NB_ADDR:0]     remaining;
    logic [NB_DATA-1:0]   word;
    logic [NB_IDX-1:0]    idx;
    logic                 accept;
    logic                 hs;
    logic                 last_byte;
    logic                 data_byte;

    // Accepted start only arms the walk; the FSM leaves IDLE on the following edge.
    assign accept    = (state == IDLE) && !armed && i_start && i_halt;
    assign hs        = (state == SEND) && bus.tx_ready;
    assign last_byte = (idx == NB_IDX'(NBYTES - 1));
`ifdef DBG_MEM_ADDR_TAG_EN
    assign data_byte = (idx != '0);
`else
    assign data_byte = 1'b1;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (armed) state_next = (remaining == '0) ? DONE : LOAD;
            LOAD: state_next = i_halt ? SEND : IDLE;
            SEND: if (hs && last_byte)
                      state_next = (remaining == (NB_ADDR+1)'(1)) ? DONE : LOAD;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed     <= 1'b0;
            aborted_q <= 1'b0;
            addr      <= '0;
            remaining <= '0;
            word      <= '0;
            idx       <= '0;
        end else begin
            armed     <= accept;
            aborted_q <= (state == LOAD) && !i_halt;
            if (accept) begin
                addr      <= i_base_addr;
                remaining <= i_count;
            end
            if (state == LOAD && i_halt) begin
                word <= bus.mem_data;
                idx  <= '0;
            end
            if (hs) begin
                idx <= idx + NB_IDX'(1);
                if (data_byte) word <= word << 8;
                if (last_byte) begin
                    remaining <= remaining - (NB_ADDR+1)'(1);
                    if (remaining != (NB_ADDR+1)'(1)) addr <= addr + NB_ADDR'(1);
                end
            end
        end
    end

    always_comb begin
        bus.tx_data = '0;
        if (state == SEND) begin
            if (data_byte) bus.tx_data = word[NB_DATA-1 -: 8];
            else           bus.tx_data = 8'(addr);
        end
    end

    assign bus.mem_addr = addr;
    assign bus.tx_valid = (state == SEND);
    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);
    assign o_aborted    = aborted_q;
endmodule
